// File: rtl/winner_policy_ng.sv
`default_nettype none
// winner_policy_ng: epsilon-greedy next-hop selector over NUM_NEIGHBORS streamed entries.
// Random-explore path (LFSR + ID table) is built only when WINNER_POLICY_EXPLORE_EN is defined.
module winner_policy_ng #(
  parameter int          VAL_WIDTH     = 16,
  parameter int          ID_WIDTH      = 16,
  parameter int          NUM_NEIGHBORS = 8,
  parameter int          IDX_WIDTH     = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic [15:0]          epsilon,
  input  logic [VAL_WIDTH-1:0] my_best,
  input  logic [ID_WIDTH-1:0]  my_besthop,
  input  logic [ID_WIDTH-1:0]  my_node_id,
  input  logic                 done_prev,
  input  logic                 nbr_valid,
  input  logic [VAL_WIDTH-1:0] nbr_value,
  input  logic [ID_WIDTH-1:0]  nbr_id,
  output logic                 nbr_ready,
  output logic                 busy,
  output logic                 done,
  output logic [ID_WIDTH-1:0]  nexthop,
  output logic                 explored
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DECIDE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [IDX_WIDTH-1:0] r_cnt;
  logic [VAL_WIDTH-1:0] r_best_val;
  logic [ID_WIDTH-1:0]  r_best_hop;
  logic [ID_WIDTH-1:0]  r_node_id_unused;
  logic [ID_WIDTH-1:0]  r_nexthop;
  logic                 r_done;
  logic                 r_explored;
  logic                 w_start;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_explore;
  logic [ID_WIDTH-1:0]  w_pick_hop;

  assign w_start  = (r_state == S_IDLE) && done_prev;
  assign w_accept = (r_state == S_COLLECT) && nbr_valid;
  assign w_last   = w_accept && (r_cnt == IDX_WIDTH'(NUM_NEIGHBORS - 1));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:    if (done_prev) w_state_next = S_COLLECT;
      S_COLLECT: if (w_last)    w_state_next = S_DECIDE;
      S_DECIDE:                 w_state_next = S_IDLE;
      default:                  w_state_next = S_IDLE;
    endcase
  end

  // Strict less-than: the local hop survives ties, and the earliest equal neighbour wins.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_cnt            <= '0;
      r_best_val       <= '0;
      r_best_hop       <= '0;
      r_node_id_unused <= '0;
    end else if (w_start) begin
      r_cnt            <= '0;
      r_best_val       <= my_best;
      r_best_hop       <= my_besthop;
      r_node_id_unused <= my_node_id;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
      if (nbr_value < r_best_val) begin
        r_best_val <= nbr_value;
        r_best_hop <= nbr_id;
      end
    end
  end

`ifdef WINNER_POLICY_EXPLORE_EN
  localparam logic [15:0] LFSR_INIT = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0]         r_lfsr;
  logic [15:0]         r_eps;
  logic [ID_WIDTH-1:0] r_tbl [NUM_NEIGHBORS];

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_lfsr <= LFSR_INIT;
      r_eps  <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      if (w_start) r_eps <= epsilon;
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) r_tbl[r_cnt] <= nbr_id;
  end

  assign w_explore  = (r_lfsr <= r_eps);
  assign w_pick_hop = w_explore ? r_tbl[r_lfsr[IDX_WIDTH-1:0]] : r_best_hop;
`else
  logic [15:0]         w_unused_epsilon;
  logic [ID_WIDTH-1:0] w_unused_nbr_id;

  assign w_unused_epsilon = epsilon;
  assign w_unused_nbr_id  = nbr_id;
  assign w_explore        = 1'b0;
  assign w_pick_hop       = r_best_hop;
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_done     <= 1'b0;
      r_nexthop  <= '0;
      r_explored <= 1'b0;
    end else if (r_state == S_DECIDE) begin
      r_done     <= 1'b1;
      r_nexthop  <= w_pick_hop;
      r_explored <= w_explore;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign nbr_ready = (r_state == S_COLLECT);
  assign done      = r_done;
  assign nexthop   = r_nexthop;
  assign explored  = r_explored;

endmodule
`default_nettype wire

// File: tb/tb_winner_policy_ng.sv
`default_nettype none
// tb_winner_policy_ng: directed + randomized checks of winner_policy_ng against a behavioural model.
// Explore expectations follow WINNER_POLICY_EXPLORE_EN the same way the design build does.
module tb_winner_policy_ng;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        nreset;
  logic [15:0] epsilon, my_best, my_besthop, my_node_id;
  logic        done_prev, nbr_valid;
  logic [15:0] nbr_value, nbr_id;
  logic        nbr_ready, busy, done, explored;
  logic [15:0] nexthop;

  int errors = 0;
  int checks = 0;
  int cyc;

  logic [15:0] costs [N];
  logic [15:0] ids   [N];
  logic [15:0] t_eps, t_best, t_hop;
  logic [15:0] prev_hop;
  bit          saw_done;

  always #5 clk = ~clk;

  winner_policy_ng dut (
    .clock(clk), .nreset(nreset), .epsilon(epsilon), .my_best(my_best),
    .my_besthop(my_besthop), .my_node_id(my_node_id), .done_prev(done_prev),
    .nbr_valid(nbr_valid), .nbr_value(nbr_value), .nbr_id(nbr_id),
    .nbr_ready(nbr_ready), .busy(busy), .done(done), .nexthop(nexthop),
    .explored(explored)
  );

  // Rising edges seen since reset was released; the LFSR has stepped exactly this often.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Taps 16,14,13,11 of the polynomial are register bits 15,13,12,10 (mask 16'hB400).
  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] v = 16'hACE1;
    for (int i = 0; i < n; i++) v = {v[14:0], ^(v & 16'hB400)};
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic decide(input string tag, input int gap, input bit chain, input bit stray);
    int          lat;
    logic [15:0] bv, bh, l, exp_hop;
    bit          ex;
    if (!chain) @(negedge clk);
    done_prev = 1'b1; epsilon = t_eps; my_best = t_best; my_besthop = t_hop;
    my_node_id = 16'($urandom);
    lat = 0;
    @(negedge clk); lat++;
    done_prev = 1'b0;
    epsilon = 16'($urandom); my_best = 16'($urandom); my_besthop = 16'($urandom);
    for (int i = 0; i < N; i++) begin
      nbr_valid = 1'b1; nbr_value = costs[i]; nbr_id = ids[i];
      @(negedge clk); lat++;
      nbr_valid = 1'b0; nbr_value = 16'($urandom); nbr_id = 16'($urandom);
      if (i < N - 1) begin
        for (int g = 0; g < gap; g++) begin
          done_prev = stray && (g == 0);
          @(negedge clk); lat++;
        end
      end
      done_prev = 1'b0;
    end
    check({tag, " held"}, nexthop, prev_hop);
    check({tag, " busy"}, busy, 1'b1);
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk); lat++;
    end
    check({tag, " done"}, done, 1'b1);
    check({tag, " latency"}, lat, 10 + gap * (N - 1));
    bv = t_best; bh = t_hop;
    for (int i = 0; i < N; i++) if (costs[i] < bv) begin bv = costs[i]; bh = ids[i]; end
    l = lfsr_after(cyc - 1);
`ifdef WINNER_POLICY_EXPLORE_EN
    ex = (l <= t_eps);
`else
    ex = 1'b0;
`endif
    exp_hop = ex ? ids[l % N] : bh;
    check({tag, " nexthop"}, nexthop, exp_hop);
    check({tag, " explored"}, explored, ex);
    prev_hop = exp_hop;
  endtask

  task automatic load_t2();
    logic [15:0] c [N] = '{16'd90, 16'd40, 16'd70, 16'd40, 16'd60, 16'd80, 16'd95, 16'd99};
    for (int i = 0; i < N; i++) begin costs[i] = c[i]; ids[i] = 16'(10 + i); end
    t_eps = 16'd0; t_best = 16'd50; t_hop = 16'd3;
  endtask

  initial begin
    nreset = 1'b1; done_prev = 1'b0; nbr_valid = 1'b0; epsilon = '0; my_best = '0;
    my_besthop = '0; my_node_id = '0; nbr_value = '0; nbr_id = '0; prev_hop = '0;
    #2 nreset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst done", done, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst ready", nbr_ready, 1'b0);
    check("rst nexthop", nexthop, 16'd0);
    check("rst explored", explored, 1'b0);
    nreset = 1'b1;

    load_t2();
    decide("T2 greedy", 0, 1'b0, 1'b0);
    check("T2 fixed hop", nexthop, 16'd11);
    @(negedge clk);
    check("T2 done pulse", done, 1'b0);
    check("T2 idle", busy, 1'b0);

    load_t2(); t_best = 16'd40;
    decide("T3 tie", 0, 1'b0, 1'b0);
    check("T3 fixed hop", nexthop, 16'd3);

    for (int i = 0; i < N; i++) begin costs[i] = 16'($urandom_range(0, 200)); ids[i] = 16'(20 + i); end
    t_eps = 16'hFFFF; t_best = 16'd100; t_hop = 16'd5;
    decide("T4 explore", 0, 1'b0, 1'b0);

    load_t2();
    decide("T5 stall", 3, 1'b0, 1'b1);

    for (int r = 0; r < 12; r++) begin
      case ($urandom_range(0, 3))
        0: t_eps = 16'h0000;
        1: t_eps = 16'hFFFF;
        default: t_eps = 16'($urandom);
      endcase
      for (int i = 0; i < N; i++) begin
        costs[i] = 16'($urandom_range(0, 255)); ids[i] = 16'($urandom);
      end
      t_best = 16'($urandom_range(0, 300)); t_hop = 16'($urandom);
      decide("T6 chain", $urandom_range(0, 2), 1'b1, 1'b0);
    end

    load_t2();
    decide("T1 pre", 0, 1'b0, 1'b0);
    @(negedge clk);
    done_prev = 1'b1; epsilon = t_eps; my_best = t_best; my_besthop = t_hop;
    @(negedge clk);
    done_prev = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nbr_valid = 1'b1; nbr_value = costs[i]; nbr_id = ids[i];
      @(negedge clk);
    end
    check("T1 ready before", nbr_ready, 1'b1);
    nreset = 1'b0;
    #1;
    check("T1 done", done, 1'b0);
    check("T1 busy", busy, 1'b0);
    check("T1 nexthop", nexthop, 16'd0);
    check("T1 ready", nbr_ready, 1'b0);
    nbr_valid = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    check("T1 no resume", saw_done, 1'b0);
    prev_hop = 16'd0;
    decide("T1 after", 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
